vga_rect_master: RTL

VGA_RECT_MASTER -- requirements
Module: vga_rect_master

---
 rtl/vga_pkg.sv | 43 ++++
 rtl/vga_rect_master.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the rectangle-fill VGA master:
//   - fill FSM state encoding
//   - CSR word addresses of the slave register map
//   - screen limits (160 x 120) and the last legal x / y coordinate
//   - pack_pixel(): builds the word the pixel-plot slave expects
// -----------------------------------------------------------------------------
package vga_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] CSR_CTRL     = 4'd0;
  localparam logic [3:0] CSR_CORNER_A = 4'd1;
  localparam logic [3:0] CSR_CORNER_B = 4'd2;
  localparam logic [3:0] CSR_COLOUR   = 4'd3;
  localparam logic [3:0] CSR_PIXCOUNT = 4'd4;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
  localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 1);

  // One screen coordinate as held in the corner registers.
  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
  } point_t;

  // Pixel word layout: {13'b0, colour[2:0], x[7:0], 1'b0, y[6:0]}.
  function automatic logic [31:0] pack_pixel(input logic [2:0] colour,
                                             input logic [7:0] x,
                                             input logic [6:0] y);
    return {13'b0, colour, x, 1'b0, y};
  endfunction

endpackage : vga_pkg

// File: rtl/vga_rect_master.sv
// -----------------------------------------------------------------------------
// vga_rect_master
// Fills an axis-aligned rectangle on a 160x120 screen by issuing one Avalon-MM
// write per pixel to a pixel-plot slave at VGA_BASE. Software programs two
// corners and a colour through the CSR slave port, then writes start.
//
// Ports
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   address/read/readdata/write/writedata
//                     : Avalon-MM CSR slave, zero wait states, registered read
//                       0 CTRL/STATUS (wr bit0 start; rd bit0 busy, bit1 done)
//                       1 corner A, 2 corner B ([15:8] x, [6:0] y)
//                       3 COLOUR ([2:0]), 4 PIXCOUNT (read-only)
//   m_address/m_write/m_writedata/m_waitrequest
//                     : Avalon-MM master write port to the pixel-plot slave
// -----------------------------------------------------------------------------
module vga_rect_master
  import vga_pkg::*;
#(
  parameter logic [31:0] VGA_BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  // CSR slave
  input  logic [3:0]  address,
  input  logic        read,
  output logic [31:0] readdata,
  input  logic        write,
  input  logic [31:0] writedata,
  // pixel master
  output logic [31:0] m_address,
  output logic        m_write,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest
);

  state_t state, state_next;

  // Software-visible registers
  point_t     corner_a, corner_b;
  logic [2:0] colour_reg;
  logic [14:0] pixcount;
  logic        done;

  // Fill-private copies, frozen in SETUP so CSR writes cannot disturb a fill
  logic [2:0] fill_colour;
  logic [7:0] x_min, x_max, x_cnt;
  logic [6:0] y_max, y_cnt;

  // Ordered and clipped view of the current corner registers
  logic [7:0] ord_x_min, ord_x_max, clip_x_max;
  logic [6:0] ord_y_min, ord_y_max, clip_y_max;
  logic       fill_empty;

  logic        busy;
  logic        start_req;
  logic        last_pixel;
  logic [31:0] rd_mux;

  // Only [15:8], [6:0] and [2:0] of writedata carry register fields.
  logic unused_wdata_bits;
  assign unused_wdata_bits = ^{writedata[31:16], writedata[7]};

  assign busy       = (state != ST_IDLE);
  assign start_req  = write && (address == CSR_CTRL) && writedata[0];
  assign last_pixel = (x_cnt == x_max) && (y_cnt == y_max);

  // ---------------------------------------------------------------------------
  // Corner ordering and clipping. Only the max edge is clipped; a min edge off
  // screen means nothing is visible, which SETUP turns into an empty fill.
  // ---------------------------------------------------------------------------
  always_comb begin
    ord_x_min  = (corner_a.x < corner_b.x) ? corner_a.x : corner_b.x;
    ord_x_max  = (corner_a.x < corner_b.x) ? corner_b.x : corner_a.x;
    ord_y_min  = (corner_a.y < corner_b.y) ? corner_a.y : corner_b.y;
    ord_y_max  = (corner_a.y < corner_b.y) ? corner_b.y : corner_a.y;
    clip_x_max = (ord_x_max > X_LAST) ? X_LAST : ord_x_max;
    clip_y_max = (ord_y_max > Y_LAST) ? Y_LAST : ord_y_max;
    fill_empty = (ord_x_min > X_LAST) || (ord_y_min > Y_LAST);
  end

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others; blocking here would create order races.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and master outputs. The master port is decoded straight
  // from the state and frozen fill registers, so reset in any cycle drops
  // m_write on the very next cycle and the word cannot change while stalled.
  // ---------------------------------------------------------------------------
  // NOTE: every output of a combinational block gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_next  = state;
    m_write     = 1'b0;
    m_address   = '0;
    m_writedata = '0;

    unique case (state)
      ST_IDLE: begin
        if (start_req) state_next = ST_SETUP;
      end
      ST_SETUP: begin
        state_next = fill_empty ? ST_DONE : ST_WRITE;
      end
      ST_WRITE: begin
        m_write     = 1'b1;
        m_address   = VGA_BASE;
        m_writedata = pack_pixel(fill_colour, x_cnt, y_cnt);
        if (!m_waitrequest && last_pixel) state_next = ST_DONE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // CSR read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_mux = '0;
    case (address)
      CSR_CTRL:     rd_mux = {30'b0, done, busy};
      CSR_CORNER_A: rd_mux = {16'b0, corner_a.x, 1'b0, corner_a.y};
      CSR_CORNER_B: rd_mux = {16'b0, corner_b.x, 1'b0, corner_b.y};
      CSR_COLOUR:   rd_mux = {29'b0, colour_reg};
      CSR_PIXCOUNT: rd_mux = {17'b0, pixcount};
      default:      rd_mux = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // CSR registers, fill datapath and registered read data
  // ---------------------------------------------------------------------------
  // NOTE: reset clears every register here, including the fill-private ones,
  // so nothing from an aborted fill survives into the next one.
  always_ff @(posedge clk) begin
    if (reset) begin
      corner_a    <= '0;
      corner_b    <= '0;
      colour_reg  <= '0;
      pixcount    <= '0;
      done        <= 1'b0;
      fill_colour <= '0;
      x_min       <= '0;
      x_max       <= '0;
      x_cnt       <= '0;
      y_max       <= '0;
      y_cnt       <= '0;
      readdata    <= '0;
    end else begin
      // Corner and colour writes are accepted at any time; an active fill
      // works from its own copies taken in SETUP.
      if (write) begin
        case (address)
          CSR_CORNER_A: corner_a   <= '{x: writedata[15:8], y: writedata[6:0]};
          CSR_CORNER_B: corner_b   <= '{x: writedata[15:8], y: writedata[6:0]};
          CSR_COLOUR:   colour_reg <= writedata[2:0];
          default:      ;
        endcase
      end

      case (state)
        ST_SETUP: begin
          fill_colour <= colour_reg;
          x_min       <= ord_x_min;
          x_max       <= clip_x_max;
          y_max       <= clip_y_max;
          x_cnt       <= ord_x_min;
          y_cnt       <= ord_y_min;
          pixcount    <= '0;
          done        <= 1'b0;
        end
        ST_WRITE: begin
          if (!m_waitrequest) begin
            pixcount <= pixcount + 15'd1;
            // Raster order, x fastest. On the final pixel the counters hold;
            // the FSM leaves WRITE on the same edge.
            if (x_cnt != x_max) begin
              x_cnt <= x_cnt + 8'd1;
            end else if (y_cnt != y_max) begin
              x_cnt <= x_min;
              y_cnt <= y_cnt + 7'd1;
            end
          end
        end
        ST_DONE: begin
          done <= 1'b1;
        end
        default: ;
      endcase

      if (read) readdata <= rd_mux;
    end
  end

endmodule : vga_rect_master
